// File: rtl/register_file_v2_pkg.sv
// regfile_pkg: shared defaults, error flag indices and types for register_file_v2
package regfile_pkg;
   localparam int XLEN_DEF     = 32;
   localparam int NREG_DEF     = 32;
   localparam int ERR_W        = 8;
   localparam int ERR_WCOLL    = 0;
   localparam int ERR_WAW      = 1;
   localparam int ERR_UNISSUED = 2;
   typedef logic [ERR_W-1:0] err_vec_t;
endpackage

// File: rtl/register_file_v2_read_port.sv
// rf_read_port: one combinational read port with x0 force, priority bypass and busy view
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                 rst,
   input  logic [AW-1:0]        rd_addr,
   input  logic [NREG*XLEN-1:0] regs,
   input  logic [NREG-1:0]      busy,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic                 issue_en,
   input  logic [AW-1:0]        issue_rd,
   output logic [XLEN-1:0]      rd_data,
   output logic                 rd_busy
);
   logic [XLEN-1:0] w_data;
   logic            w_hit;
   logic            w_issue;
   // array value, overridden by the highest-index enabled write to the same non-zero register
   always_comb begin
      w_data = regs[rd_addr*XLEN +: XLEN];
      w_hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == rd_addr && rd_addr != '0) begin
            w_data = wr_data[j*XLEN +: XLEN];
            w_hit  = 1'b1;
         end
      end
   end
   assign w_issue = issue_en && issue_rd == rd_addr;
   assign rd_data = (rst || rd_addr == '0) ? '0 : w_data;
   assign rd_busy = !rst && rd_addr != '0 && busy[rd_addr] && !(w_hit && !w_issue);
endmodule

// File: rtl/register_file_v2.sv
// register_file_v2: multi-port register file with bypass, pending scoreboard and sticky errors
module register_file_v2
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   output logic                issue_hazard,
   input  logic                err_clr,
   output logic [ERR_W-1:0]    err_vec
);
   logic [XLEN-1:0]      r_regs [NREG];
   logic [NREG*XLEN-1:0] w_regs;
   logic [NREG-1:0]      r_busy;
   logic [NREG-1:0]      w_busy_nxt;
   logic [NREG-1:0]      w_wr_hit;
   err_vec_t             r_err;
   err_vec_t             w_err_set;

   assign issue_hazard = !rst && issue_en && issue_rd != '0 && r_busy[issue_rd];
   assign err_vec      = r_err;

   // mark registers written this cycle and raise collision / unissued / WAW events
   always_comb begin
      w_wr_hit  = '0;
      w_err_set = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
            if (w_wr_hit[wr_addr[j*AW +: AW]]) w_err_set[ERR_WCOLL] = 1'b1;
            if (!r_busy[wr_addr[j*AW +: AW]]) w_err_set[ERR_UNISSUED] = 1'b1;
            w_wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
         end
      end
      w_err_set[ERR_WAW] = issue_hazard;
   end

   genvar g;
   generate
      for (g = 0; g < NREG; g++) begin : g_reg
         assign w_regs[g*XLEN +: XLEN] = r_regs[g];
         assign w_busy_nxt[g] = (g != 0 && issue_en && issue_rd == AW'(g)) ? 1'b1 :
                                w_wr_hit[g] ? 1'b0 : r_busy[g];
      end
   endgenerate

   // storage write in ascending port order so the highest colliding port lands last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
   end

   // scoreboard and sticky errors; a new event beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         r_err  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_err  <= (err_clr ? '0 : r_err) | w_err_set;
      end
   end

   genvar i;
   generate
      for (i = 0; i < NRD; i++) begin : g_rd
         rf_read_port #(
            .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .BYPASS(BYPASS)
         ) u_rd (
            .rst(rst),
            .rd_addr(rd_addr[i*AW +: AW]),
            .regs(w_regs),
            .busy(r_busy),
            .wr_en(wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .issue_en(issue_en),
            .issue_rd(issue_rd),
            .rd_data(rd_data[i*XLEN +: XLEN]),
            .rd_busy(rd_busy[i])
         );
      end
   endgenerate
endmodule

// File: tb/tb_register_file_v2.sv
// tb_register_file_v2: directed checks of default, no-bypass and wide/multi-port builds
module tb_register_file_v2;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data1;
   logic [1:0]  rd_busy, rd_busy1;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        hz, hz1;
   logic        err_clr;
   logic [7:0]  err, err1;

   logic [15:0]  rd_addr2;
   logic [255:0] rd_data2;
   logic [3:0]   rd_busy2;
   logic [2:0]   wr_en2;
   logic [11:0]  wr_addr2;
   logic [191:0] wr_data2;
   logic         issue_en2;
   logic [3:0]   issue_rd2;
   logic         hz2;
   logic         err_clr2;
   logic [7:0]   err2;

   always #5 clk = ~clk;

   register_file_v2 u0 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
      .issue_rd(issue_rd), .issue_hazard(hz), .err_clr(err_clr), .err_vec(err)
   );

   register_file_v2 #(.BYPASS(0)) u1 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
      .issue_rd(issue_rd), .issue_hazard(hz1), .err_clr(err_clr), .err_vec(err1)
   );

   register_file_v2 #(.XLEN(64), .NREG(16), .NRD(4), .NWR(3)) u2 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .issue_en(issue_en2),
      .issue_rd(issue_rd2), .issue_hazard(hz2), .err_clr(err_clr2), .err_vec(err2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_rd = '0; err_clr = 1'b0;
      wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; issue_en2 = 1'b0; issue_rd2 = '0; err_clr2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd_addr = '0; rd_addr2 = '0;
      idle();
      tick();
      chk("rst_rd0", rd_data, 64'h0);
      chk("rst_err", err, 8'h00);
      chk("rst_err2", err2, 8'h00);
      rst = 1'b0;
      // reset mid-cycle clears state asynchronously
      wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEAD;
      tick(); idle();
      rd_addr[4:0] = 5'd5;
      #1 chk("x5_written", rd_data[31:0], 32'hDEAD);
      chk("x5_unissued_err", err, 8'h04);
      issue_en = 1'b1; issue_rd = 5'd6;
      tick(); idle();
      rd_addr[9:5] = 5'd6;
      #1 chk("x6_busy", rd_busy, 2'b10);
      #2 rst = 1'b1;
      #1 chk("async_rst_rd", rd_data[31:0], 32'h0);
      chk("async_rst_busy", rd_busy, 2'b00);
      chk("async_rst_err", err, 8'h00);
      #1 rst = 1'b0;
      #1 chk("post_rst_x5", rd_data[31:0], 32'h0);
      chk("post_rst_busy", rd_busy, 2'b00);
      // x0 is hardwired zero
      rd_addr = '0;
      wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF_FFFF;
      #1 chk("x0_no_bypass", rd_data[31:0], 32'h0);
      tick(); idle();
      #1 chk("x0_read", rd_data[31:0], 32'h0);
      chk("x0_err", err, 8'h00);
      // bypass vs no bypass
      wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'h1111;
      tick(); idle();
      wr_en = 2'b10; wr_addr[9:5] = 5'd7; wr_data[63:32] = 32'h1234; rd_addr[4:0] = 5'd7;
      #1 chk("bypass_on", rd_data[31:0], 32'h1234);
      chk("bypass_off_old", rd_data1[31:0], 32'h1111);
      tick(); idle();
      #1 chk("bypass_off_new", rd_data1[31:0], 32'h1234);
      // write collision on an issued register
      err_clr = 1'b1;
      tick(); idle();
      #1 chk("err_clr", err, 8'h00);
      issue_en = 1'b1; issue_rd = 5'd3; rd_addr[4:0] = 5'd3;
      tick(); idle();
      #1 chk("x3_busy", rd_busy[0], 1'b1);
      wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'hB, 32'hA};
      #1 chk("coll_bypass", rd_data[31:0], 32'hB);
      chk("coll_busy_byp", rd_busy[0], 1'b0);
      chk("coll_busy_nobyp", rd_busy1[0], 1'b1);
      tick(); idle();
      #1 chk("coll_data", rd_data[31:0], 32'hB);
      chk("coll_err", err, 8'h01);
      chk("coll_busy_clr", rd_busy[0], 1'b0);
      // scoreboard
      err_clr = 1'b1;
      tick(); idle();
      issue_en = 1'b1; issue_rd = 5'd9;
      tick(); idle();
      rd_addr[9:5] = 5'd9;
      #1 chk("x9_busy", rd_busy[1], 1'b1);
      chk("x9_err_none", err, 8'h00);
      issue_en = 1'b1; issue_rd = 5'd9;
      #1 chk("waw_hazard", hz, 1'b1);
      tick(); idle();
      #1 chk("waw_err", err, 8'h02);
      chk("waw_busy", rd_busy[1], 1'b1);
      wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h55; issue_en = 1'b1; issue_rd = 5'd9;
      #1 chk("wr_issue_busy_now", rd_busy[1], 1'b1);
      tick(); idle();
      #1 chk("wr_issue_busy", rd_busy[1], 1'b1);
      chk("wr_issue_data", rd_data[63:32], 32'h55);
      wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h99;
      #1 chk("wb_busy_byp", rd_busy[1], 1'b0);
      chk("wb_busy_nobyp", rd_busy1[1], 1'b1);
      tick(); idle();
      #1 chk("wb_busy", rd_busy[1], 1'b0);
      chk("wb_data", rd_data[63:32], 32'h99);
      chk("wb_err", err, 8'h02);
      // error flags
      err_clr = 1'b1;
      tick(); idle();
      #1 chk("clr2", err, 8'h00);
      wr_en = 2'b10; wr_addr[9:5] = 5'd4; wr_data[63:32] = 32'h4;
      tick(); idle();
      #1 chk("unissued", err, 8'h04);
      err_clr = 1'b1;
      tick(); idle();
      #1 chk("clr3", err, 8'h00);
      issue_en = 1'b1; issue_rd = 5'd3;
      tick(); idle();
      err_clr = 1'b1; wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2, 32'h1};
      tick(); idle();
      #1 chk("clr_vs_coll", err, 8'h01);
      chk("clr_vs_coll_data", rd_data[31:0], 32'h2);
      // wide build: XLEN=64, NREG=16, NRD=4, NWR=3
      rd_addr2 = {4'd0, 4'd2, 4'd1, 4'd15};
      wr_en2 = 3'b101; wr_addr2[3:0] = 4'd1; wr_addr2[11:8] = 4'd15;
      wr_data2[63:0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_data2[191:128] = 64'h0123_4567_89AB_CDEF;
      #1 chk("w_byp_p0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
      chk("w_byp_p1", rd_data2[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("w_byp_p3", rd_data2[255:192], 64'h0);
      tick(); idle();
      #1 chk("w_p0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
      chk("w_p1", rd_data2[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("w_err_unissued", err2, 8'h04);
      err_clr2 = 1'b1; issue_en2 = 1'b1; issue_rd2 = 4'd2;
      tick(); idle();
      #1 chk("w_clr", err2, 8'h00);
      chk("w_busy", rd_busy2, 4'b0100);
      wr_en2 = 3'b111; wr_addr2 = {4'd2, 4'd2, 4'd2}; wr_data2 = {64'h3, 64'h2, 64'h1};
      #1 chk("w_coll_byp", rd_data2[191:128], 64'h3);
      tick(); idle();
      #1 chk("w_coll_data", rd_data2[191:128], 64'h3);
      chk("w_coll_err", err2, 8'h01);
      chk("w_coll_busy", rd_busy2, 4'b0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
